// File: rtl/frac_align_norm.sv
// Align / add-subtract / normalize (/ round) stage of the 4-bit-fraction FP adder, one shift per cycle.
// Optional round-to-nearest-even stage compiled in with FRAC_ROUND_EN.
module frac_align_norm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] Bigger_Frac,
    input  logic [3:0] Smaller_Frac,
    input  logic [3:0] Big_Exp,
    input  logic [3:0] Shift_Amt,
    input  logic       Sub,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] Result_Frac,
    output logic [3:0] Result_Exp,
    output logic       Ovf,
    output logic       Unf,
    output logic       Zero,
    output logic [2:0] dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // out_valid and the result hold steady until out_ready is seen.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
`ifdef FRAC_ROUND_EN
        S_ROUND = 3'd4,
`endif
        S_OUT   = 3'd5
    } state_t;

`ifdef FRAC_ROUND_EN
    localparam state_t EXIT_STATE = S_ROUND;
`else
    localparam state_t EXIT_STATE = S_OUT;
`endif

    // Working registers: {carry, 4-bit fraction, G, R, S}
    state_t      state_q, state_n;
    logic [7:0]  a_q, a_n, b_q, b_n;
    logic [3:0]  e_q, e_n;
    logic [2:0]  cnt_q, cnt_n;
    logic        sub_q, sub_n;
    logic        ovf_q, ovf_n, unf_q, unf_n, zero_q, zero_n;
    logic [3:0]  frac_q, frac_n, exp_q, exp_n;

    always_comb begin
        state_n = state_q;
        a_n     = a_q;
        b_n     = b_q;
        e_n     = e_q;
        cnt_n   = cnt_q;
        sub_n   = sub_q;
        ovf_n   = ovf_q;
        unf_n   = unf_q;
        zero_n  = zero_q;
        frac_n  = frac_q;
        exp_n   = exp_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_n    = {1'b0, Bigger_Frac, 3'b000};
                    b_n    = {1'b0, Smaller_Frac, 3'b000};
                    e_n    = Big_Exp;
                    sub_n  = Sub;
                    // Six shifts already push B entirely into sticky
                    cnt_n  = (Shift_Amt > 4'd6) ? 3'd6 : Shift_Amt[2:0];
                    ovf_n  = 1'b0;
                    unf_n  = 1'b0;
                    zero_n = 1'b0;
                    frac_n = 4'h0;
                    exp_n  = 4'h0;
                    state_n = (cnt_n != 3'd0) ? S_ALIGN : S_ADD;
                end
            end
            S_ALIGN: begin
                b_n   = {1'b0, b_q[7:2], b_q[1] | b_q[0]};
                cnt_n = cnt_q - 3'd1;
                if (cnt_q == 3'd1) state_n = S_ADD;
            end
            S_ADD: begin
                a_n     = sub_q ? (a_q - b_q) : (a_q + b_q);
                state_n = S_NORM;
            end
            S_NORM: begin
                if (a_q == 8'h00) begin
                    zero_n  = 1'b1;
                    e_n     = 4'h0;
                    state_n = EXIT_STATE;
                end else if (a_q[7]) begin
                    if (e_q == 4'hF) begin
                        ovf_n   = 1'b1;
                        a_n     = {1'b0, 4'hF, 3'b000};
                        e_n     = 4'hF;
                        state_n = S_OUT;
                    end else begin
                        a_n     = {1'b0, a_q[7:2], a_q[1] | a_q[0]};
                        e_n     = e_q + 4'd1;
                        state_n = EXIT_STATE;
                    end
                end else if (!a_q[6]) begin
                    if (e_q == 4'h0) begin
                        unf_n   = 1'b1;
                        state_n = EXIT_STATE;
                    end else begin
                        a_n = {a_q[6:0], 1'b0};
                        e_n = e_q - 4'd1;
                    end
                end else begin
                    state_n = EXIT_STATE;
                end
            end
`ifdef FRAC_ROUND_EN
            S_ROUND: begin
                if (a_q[2] && (a_q[1] || a_q[0] || a_q[3])) begin
                    if (a_q[6:3] == 4'hF) begin
                        if (e_q == 4'hF) begin
                            ovf_n = 1'b1;
                            a_n   = {1'b0, 4'hF, 3'b000};
                        end else begin
                            a_n = {1'b0, 4'h8, 3'b000};
                            e_n = e_q + 4'd1;
                        end
                    end else begin
                        a_n = {1'b0, a_q[6:3] + 4'd1, 3'b000};
                    end
                end
                state_n = S_OUT;
            end
`endif
            S_OUT: begin
                if (out_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        // Result registers latch once, on entry to OUT, and hold until the next capture
        if (state_n == S_OUT && state_q != S_OUT) begin
            frac_n = a_n[6:3];
            exp_n  = e_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= 8'h00;
            b_q    <= 8'h00;
            e_q    <= 4'h0;
            cnt_q  <= 3'd0;
            sub_q  <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            zero_q <= 1'b0;
            frac_q <= 4'h0;
            exp_q  <= 4'h0;
        end else begin
            a_q    <= a_n;
            b_q    <= b_n;
            e_q    <= e_n;
            cnt_q  <= cnt_n;
            sub_q  <= sub_n;
            ovf_q  <= ovf_n;
            unf_q  <= unf_n;
            zero_q <= zero_n;
            frac_q <= frac_n;
            exp_q  <= exp_n;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_OUT);
    assign Result_Frac = frac_q;
    assign Result_Exp  = exp_q;
    assign Ovf         = ovf_q;
    assign Unf         = unf_q;
    assign Zero        = zero_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_frac_align_norm.sv
// Self-checking bench for frac_align_norm; expectations follow FRAC_ROUND_EN when defined.
module tb_frac_align_norm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] bigger_frac, smaller_frac, big_exp, shift_amt;
    logic       sub;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] result_frac, result_exp;
    logic       ovf, unf, zero;
    logic [2:0] dbg_state;

    int total = 0;
    int bad   = 0;

    // Expected word: {frac, exp, ovf, unf, zero}
    logic [10:0] exp_q[$];
    int          lat_q[$];

`ifdef FRAC_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif

    frac_align_norm dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .Bigger_Frac(bigger_frac), .Smaller_Frac(smaller_frac), .Big_Exp(big_exp),
        .Shift_Amt(shift_amt), .Sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .Result_Frac(result_frac), .Result_Exp(result_exp), .Ovf(ovf), .Unf(unf),
        .Zero(zero), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] out_word();
        return {result_frac, result_exp, ovf, unf, zero};
    endfunction

    // Integer reference model of align / add / normalize / round
    function automatic int model(input int bf, input int sf, input int be, input int sa,
                                 input int sb, output logic [10:0] w);
        int a, b, e, s, k, f;
        logic o, u, z, sat, done;
        logic [3:0] fr, ex;
        a = bf * 8; b = sf * 8; e = be; s = (sa > 6) ? 6 : sa;
        o = 0; u = 0; z = 0; sat = 0; done = 0; k = 0;
        for (int i = 0; i < s; i++) b = (b >> 1) | (b & 1);
        a = sb ? ((a - b) & 255) : (a + b);
        while (!done) begin
            if (a == 0) begin
                z = 1; e = 0; done = 1;
            end else if (a >= 128) begin
                a = (a >> 1) | (a & 1);
                if (e == 15) begin o = 1; sat = 1; a = 15 * 8; end
                else e = e + 1;
                done = 1;
            end else if (a < 64) begin
                if (e == 0) begin u = 1; done = 1; end
                else begin a = a * 2; e = e - 1; k++; end
            end else begin
                done = 1;
            end
        end
        if (RND == 1 && !sat) begin
            if (((a >> 2) & 1) == 1 && ((a & 3) != 0 || ((a >> 3) & 1) == 1)) begin
                f = (a >> 3) & 15;
                if (f == 15) begin
                    if (e == 15) o = 1;
                    else begin f = 8; e = e + 1; end
                end else f = f + 1;
                a = f * 8;
            end
        end
        fr = 4'((a >> 3) & 15);
        ex = 4'(e);
        w = {fr, ex, o, u, z};
        return s + k + 2 + ((RND == 1 && !sat) ? 1 : 0);
    endfunction

    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!out_valid && n < 64);
    endtask

    task automatic run_op(input logic [3:0] bf, input logic [3:0] sf, input logic [3:0] be,
                          input logic [3:0] sa, input logic sb, input logic [10:0] w,
                          input int lat, input int hold, input string name);
        logic [10:0] e;
        int n, el;
        exp_q.push_back(w);
        lat_q.push_back(lat);
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL %s ready_before got=%b want=1", name, in_ready);
        end
        bigger_frac = bf; smaller_frac = sf; big_exp = be; shift_amt = sa; sub = sb;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(n);
        e  = exp_q.pop_front();
        el = lat_q.pop_front();
        total++;
        if (n !== el) begin
            bad++; $display("FAIL %s latency got=%0d want=%0d", name, n, el);
        end
        total++;
        if (out_word() !== e || out_valid !== 1'b1) begin
            bad++; $display("FAIL %s result got=%h valid=%b want=%h", name, out_word(), out_valid, e);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            total++;
            if ({out_valid, out_word()} !== {1'b1, e}) begin
                bad++; $display("FAIL %s hold%0d got=%b/%h want=1/%h", name, i, out_valid, out_word(), e);
            end
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL %s accept got valid=%b ready=%b want 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        bigger_frac = 0; smaller_frac = 0; big_exp = 0; shift_amt = 0; sub = 0;
        repeat (2) @(posedge clk); #1;
        total++;
        if (out_word() !== 11'h000) begin
            bad++; $display("FAIL reset_outputs got=%h want=000", out_word());
        end
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_handshake got ready=%b valid=%b want 1/0", in_ready, out_valid);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_directed();
        // C+8 at exp 5: carry out -> 1.010 x 2^6
        run_op(4'hC, 4'h8, 4'd5, 4'd0, 1'b0, {4'hA, 4'd6, 3'b000}, 2 + RND, 5, "add_carry");
        // 8 - (F>>1) = 0.0001: four left shifts, exp 4 -> 0
        run_op(4'h8, 4'hF, 4'd4, 4'd1, 1'b1, {4'h8, 4'd0, 3'b000}, 7 + RND, 0, "sub_norm");
        run_op(4'h9, 4'h9, 4'd7, 4'd0, 1'b1, {4'h0, 4'd0, 3'b001}, 2 + RND, 1, "zero");
        run_op(4'hF, 4'hF, 4'd15, 4'd0, 1'b0, {4'hF, 4'd15, 3'b100}, 2, 2, "overflow");
        // Same difference at exp 1: exponent runs out after one shift
        run_op(4'h8, 4'hF, 4'd1, 4'd1, 1'b1, {4'h1, 4'd0, 3'b010}, 4 + RND, 0, "underflow");
        // G=1, R=S=0, odd LSB: rounds up and renormalizes only with rounding
        run_op(4'hF, 4'h8, 4'd5, 4'd4, 1'b0,
               (RND == 1) ? {4'h8, 4'd6, 3'b000} : {4'hF, 4'd5, 3'b000}, 6 + RND, 0, "round_odd");
        // G=1, R=S=0, even LSB: tie stays put
        run_op(4'hC, 4'h8, 4'd3, 4'd4, 1'b0, {4'hC, 4'd3, 3'b000}, 6 + RND, 0, "round_tie_even");
        // Shift 9 caps at 6: B fully in sticky
        run_op(4'hA, 4'hF, 4'd9, 4'd9, 1'b0, {4'hA, 4'd9, 3'b000}, 8 + RND, 0, "shift_cap");
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        bigger_frac = 4'hF; smaller_frac = 4'h8; big_exp = 4'd9; shift_amt = 4'd9; sub = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_word() !== 11'h000) begin
            bad++; $display("FAIL reset_mid_op got ready=%b valid=%b out=%h want 1/0/000",
                            in_ready, out_valid, out_word());
        end
        @(negedge clk); rst_n = 1'b1;
        run_op(4'hC, 4'h8, 4'd5, 4'd0, 1'b0, {4'hA, 4'd6, 3'b000}, 2 + RND, 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [10:0] e;
        int n, el;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({4'hA, 4'd6, 3'b000});
            lat_q.push_back(2 + RND);
        end
        @(negedge clk);
        bigger_frac = 4'hC; smaller_frac = 4'h8; big_exp = 4'd5; shift_amt = 4'd0; sub = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            wait_out(n);
            e  = exp_q.pop_front();
            el = lat_q.pop_front();
            total++;
            if (n !== el || out_word() !== e) begin
                bad++; $display("FAIL b2b_%0d got lat=%0d out=%h want lat=%0d out=%h", i, n, out_word(), el, e);
            end
            if (i == 1) in_valid = 1'b0;
            @(posedge clk); #1;
            total++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                bad++; $display("FAIL b2b_idle_%0d got ready=%b valid=%b want 1/0", i, in_ready, out_valid);
            end
            if (i == 0) begin
                @(posedge clk); #1;
                total++;
                if (in_ready !== 1'b0) begin
                    bad++; $display("FAIL b2b_recapture got ready=%b want 0", in_ready);
                end
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0] bf, sf, be, sa, t;
        logic sb;
        logic [10:0] w;
        int lat;
        for (int i = 0; i < 24; i++) begin
            bf = 4'($urandom_range(8, 15));
            sf = 4'($urandom_range(8, 15));
            sa = 4'($urandom_range(0, 9));
            be = 4'($urandom_range(0, 15));
            sb = 1'($urandom_range(0, 1));
            if (sa == 4'd0 && sf > bf) begin t = bf; bf = sf; sf = t; end
            lat = model(int'(bf), int'(sf), int'(be), int'(sa), int'(sb), w);
            run_op(bf, sf, be, sa, sb, w, lat, $urandom_range(0, 2), "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
